// File: rtl/math_host.sv
// math_host: turns wide LOAD0/LOAD1/ADD/READ0 commands into the byte-serial op/data stream of a math accumulator.
// Optional SHL/SHR commands are built only when MATH_HOST_SHIFT_EN is defined.
module math_host #(
  parameter int BITS = 128
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic [BITS-1:0] cmd_data_i,
  output logic            rsp_valid_o,
  output logic [BITS-1:0] rsp_data_o,
  output logic [7:0]      m_op_o,
  output logic [7:0]      m_data_o,
  input  logic [7:0]      m_rdata_i,
  output logic [3:0]      dbg_state_o
);

  localparam int N  = BITS / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] C_LOAD0 = 3'd0;
  localparam logic [2:0] C_LOAD1 = 3'd1;
  localparam logic [2:0] C_ADD   = 3'd2;
  localparam logic [2:0] C_READ0 = 3'd3;
`ifdef MATH_HOST_SHIFT_EN
  localparam logic [2:0] C_SHL   = 3'd4;
  localparam logic [2:0] C_SHR   = 3'd5;
`endif

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_CLR0 = 8'h02;
  localparam logic [7:0] OP_CLR1 = 8'h03;
  localparam logic [7:0] OP_LDB  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_CPY  = 8'h09;
  localparam logic [7:0] OP_SHL  = 8'h0A;
  localparam logic [7:0] OP_RST  = 8'h0B;
  localparam logic [7:0] OP_SHR  = 8'h0C;

  typedef enum logic [3:0] {
    IDLE, CLR, LOADB, SHIFT8, SUM, COPYCLR, COPY, READB, RESTORE, ALU, DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic [N-1:0][7:0]   data_q;
  logic [N-1:0][7:0]   rd_q;
  logic                rsp_valid_q;
  logic [BITS-1:0]     rsp_data_q;
  logic [7:0]          m_op_q;
  logic [7:0]          m_data_q;
  logic [CW-1:0]       cnt_dec;
  logic [CW-1:0]       cnt_inc;

  assign cnt_dec = cnt_q - CW'(1);
  assign cnt_inc = cnt_q + CW'(1);

  // Valid/ready: a command transfers on the rising edge where cmd_valid_i and
  // cmd_ready_o are both high; cmd_ready_o is high exactly while the FSM idles.
  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign m_op_o      = m_op_q;
  assign m_data_o    = m_data_q;
  assign dbg_state_o = state_q;

  // Each state names the op being driven this cycle; the edge leaving it loads the next op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      m_op_q      <= OP_NOP;
      m_data_q    <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      m_op_q      <= OP_NOP;
      m_data_q    <= 8'h00;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q   <= cmd_op_i;
            data_q <= cmd_data_i;
            cnt_q  <= '0;
            case (cmd_op_i)
              C_LOAD0: begin state_q <= CLR;     m_op_q <= OP_CLR0; end
              C_LOAD1: begin state_q <= COPYCLR; m_op_q <= OP_CLR1; end
              C_ADD:   begin state_q <= SUM;     m_op_q <= OP_ADD;  end
              C_READ0: begin state_q <= COPYCLR; m_op_q <= OP_CLR1; end
`ifdef MATH_HOST_SHIFT_EN
              C_SHL: begin
                state_q  <= ALU;
                m_op_q   <= OP_SHL;
                m_data_q <= cmd_data_i[7:0];
              end
              C_SHR: begin
                state_q  <= ALU;
                m_op_q   <= OP_SHR;
                m_data_q <= cmd_data_i[7:0];
              end
`endif
              default: state_q <= DONE;
            endcase
          end
        end
        COPYCLR: begin
          if (op_q == C_LOAD1) begin
            state_q <= CLR;
            m_op_q  <= OP_CLR0;
          end else begin
            state_q <= COPY;
            m_op_q  <= OP_CPY;
          end
        end
        CLR: begin
          state_q  <= LOADB;
          cnt_q    <= LAST;
          m_op_q   <= OP_LDB;
          m_data_q <= data_q[LAST];
        end
        LOADB: begin
          if (cnt_q != '0) begin
            state_q  <= SHIFT8;
            m_op_q   <= OP_SHL;
            m_data_q <= 8'h08;
          end else if (op_q == C_LOAD1) begin
            state_q <= COPY;
            m_op_q  <= OP_CPY;
          end else begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
          end
        end
        SHIFT8: begin
          state_q  <= LOADB;
          cnt_q    <= cnt_dec;
          m_op_q   <= OP_LDB;
          m_data_q <= data_q[cnt_dec];
        end
        COPY: begin
          if (op_q == C_READ0) begin
            state_q  <= READB;
            cnt_q    <= '0;
            m_op_q   <= OP_SHR;
            m_data_q <= 8'h08;
          end else begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
          end
        end
        READB: begin
          // m_rdata_i still shows the byte from before this cycle's shift.
          rd_q[cnt_q] <= m_rdata_i;
          if (cnt_q == LAST) begin
            state_q <= RESTORE;
            m_op_q  <= OP_RST;
          end else begin
            cnt_q    <= cnt_inc;
            m_op_q   <= OP_SHR;
            m_data_q <= 8'h08;
          end
        end
        RESTORE: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= rd_q;
        end
        SUM, ALU, DONE: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
